// File: rtl/sb_tx_serializer.sv
// Sideband transmitter: FIFO of 64-bit messages, serialized LSB-first on a forwarded clock at half rate.
// Optional `define SB_TX_LEVEL_EN adds FIFO occupancy (level_o) and sticky overflow (overflow_o) ports.
module sb_tx_serializer #(
  parameter int BUFFER_SIZE = 4,
  parameter int GAP_CYCLES  = 64
) (
  input  logic        clk_100MHz,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [63:0] data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        dataPin_o,
  output logic        clkPin_o,
  output logic        busy_o,
  output logic        done_o
`ifdef SB_TX_LEVEL_EN
  ,
  output logic [$clog2(BUFFER_SIZE):0] level_o,
  output logic        overflow_o
`endif
);

  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t      state;
  logic [63:0] mem [BUFFER_SIZE];
  logic [AW:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic        full, empty, full_nxt, push, pop;
  logic [63:0] shreg;
  logic [5:0]  bit_cnt;
  logic        phase;
  logic [GW-1:0] gap_cnt;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);
  assign push  = valid_i && !full;
  assign pop   = (state == IDLE) && enable_i && !empty;

  always_comb begin
    wptr_nxt = wptr + {{AW{1'b0}}, push};
    rptr_nxt = rptr + {{AW{1'b0}}, pop};
    full_nxt = (wptr_nxt[AW] != rptr_nxt[AW]) && (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      ready_o <= 1'b1;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      ready_o <= !full_nxt;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (push) mem[wptr[AW-1:0]] <= data_i;
  end

  // Data changes only with the rising forwarded-clock edge so it is stable at the receiver's falling edge.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      phase     <= 1'b0;
      gap_cnt   <= '0;
      dataPin_o <= 1'b0;
      clkPin_o  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          clkPin_o  <= 1'b0;
          dataPin_o <= 1'b0;
          if (pop) begin
            shreg   <= mem[rptr[AW-1:0]];
            bit_cnt <= '0;
            phase   <= 1'b0;
            busy_o  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (!phase) begin
            dataPin_o <= shreg[0];
            clkPin_o  <= 1'b1;
            phase     <= 1'b1;
          end else begin
            clkPin_o <= 1'b0;
            shreg    <= shreg >> 1;
            bit_cnt  <= bit_cnt + 6'd1;
            phase    <= 1'b0;
            if (bit_cnt == 6'd63) begin
              done_o    <= 1'b1;
              gap_cnt   <= '0;
              dataPin_o <= 1'b0;
              state     <= GAP;
            end
          end
        end
        GAP: begin
          clkPin_o  <= 1'b0;
          dataPin_o <= 1'b0;
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef SB_TX_LEVEL_EN
  assign level_o = wptr - rptr;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) overflow_o <= 1'b0;
    else if (valid_i && !ready_o) overflow_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Self-checking bench for sb_tx_serializer; a negedge monitor acts as the sideband receiver.
// Build with +define+SB_TX_LEVEL_EN to also exercise level_o/overflow_o.
module tb_sb_tx_serializer;

  localparam int BUFFER_SIZE = 4;
  localparam int GAP_CYCLES  = 64;

  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1;
  logic        enable_i = 1'b0;
  logic [63:0] data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o, dataPin_o, clkPin_o, busy_o, done_o;
`ifdef SB_TX_LEVEL_EN
  logic [$clog2(BUFFER_SIZE):0] level_o;
  logic        overflow_o;
`endif

  int checks = 0;
  int failures = 0;

  sb_tx_serializer #(.BUFFER_SIZE(BUFFER_SIZE), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .enable_i(enable_i), .data_i(data_i),
    .valid_i(valid_i), .ready_o(ready_o), .dataPin_o(dataPin_o), .clkPin_o(clkPin_o),
    .busy_o(busy_o), .done_o(done_o)
`ifdef SB_TX_LEVEL_EN
    , .level_o(level_o), .overflow_o(overflow_o)
`endif
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int cyc = 0;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  // Receiver model: sample data while the forwarded clock is high, commit it on the falling edge.
  logic [63:0] rx_q [$];
  int          start_q [$];
  int          spacing_q [$];
  logic [63:0] rx_word = '0;
  int  rx_bits = 0, rise_cnt = 0, done_cnt = 0, done_err = 0, gap_data_err = 0;
  int  last_fall = 0, done_cyc = 0;
  bit  have_fall = 0, prev_clk = 0, cur_bit = 0, completed = 0;

  always @(negedge clk_100MHz) begin
    if (reset) begin
      prev_clk = 0;
      rx_bits = 0;
      have_fall = 0;
    end else begin
      if (clkPin_o && !prev_clk) begin
        if (rx_bits == 0) begin
          start_q.push_back(cyc);
          if (have_fall) spacing_q.push_back(cyc - last_fall);
        end
        rise_cnt++;
      end
      if (clkPin_o) cur_bit = dataPin_o;
      completed = 0;
      if (!clkPin_o && prev_clk) begin
        rx_word[rx_bits] = cur_bit;
        rx_bits++;
        last_fall = cyc;
        have_fall = 1;
        if (rx_bits == 64) begin
          rx_q.push_back(rx_word);
          rx_bits = 0;
          completed = 1;
        end
      end
      if (!clkPin_o && rx_bits == 0 && dataPin_o !== 1'b0) gap_data_err++;
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_o !== completed) done_err++;
      prev_clk = clkPin_o;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic applyStimulus(input logic [63:0] d, output bit was_ready, output int acc_cyc);
    @(negedge clk_100MHz);
    data_i = d;
    valid_i = 1'b1;
    was_ready = ready_o;
    @(posedge clk_100MHz);
    #1;
    acc_cyc = cyc;
    valid_i = 1'b0;
    data_i = '0;
  endtask

  task automatic wait_rx(input int n, input int limit, output bit ok);
    int i = 0;
    while (rx_q.size() < n && i < limit) begin
      @(negedge clk_100MHz);
      i++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int i = 0;
    while (busy_o && i < limit) begin
      @(negedge clk_100MHz);
      i++;
    end
    ok = !busy_o;
  endtask

  task automatic wait_bits(input int n, input int limit, output bit ok);
    int i = 0;
    while (rx_bits != n && i < limit) begin
      @(negedge clk_100MHz);
      i++;
    end
    ok = (rx_bits == n);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk_100MHz);
    checks++; if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", ready_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (clkPin_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_clk: got %b expected 0", clkPin_o); end
    checks++; if (dataPin_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_data: got %b expected 0", dataPin_o); end
    checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done_o); end
`ifdef SB_TX_LEVEL_EN
    checks++; if (level_o !== '0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", level_o); end
    checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow_o); end
`endif
    reset = 1'b0;
    repeat (2) @(negedge clk_100MHz);
  endtask

  task automatic test_single();
    logic [63:0] msg = 64'hA5A5_0000_FFFF_1234;
    bit r, ok;
    int n, d0, r0, i;
    rx_q.delete();
    start_q.delete();
    d0 = done_cnt;
    r0 = rise_cnt;
    enable_i = 1'b1;
    applyStimulus(msg, r, n);
    wait_rx(1, 400, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL single_timeout: got %0d messages expected 1", rx_q.size()); end
    checks++; if (start_q.size() != 1) begin failures++; $display("[TB] FAIL single_starts: got %0d expected 1", start_q.size()); end
    else begin
      checks++; if (start_q[0] - n != 2) begin failures++; $display("[TB] FAIL single_latency: got %0d expected 2", start_q[0] - n); end
    end
    if (ok) begin
      checks++; if (rx_q[0] !== msg) begin failures++; $display("[TB] FAIL single_data: got %h expected %h", rx_q[0], msg); end
    end
    checks++; if (rise_cnt - r0 != 64) begin failures++; $display("[TB] FAIL single_edges: got %0d expected 64", rise_cnt - r0); end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("[TB] FAIL single_done: got %0d expected 1", done_cnt - d0); end
    i = 0;
    while (busy_o && i < 200) begin @(negedge clk_100MHz); i++; end
    checks++; if (busy_o || (cyc - done_cyc != GAP_CYCLES)) begin failures++; $display("[TB] FAIL single_gap: got %0d expected %0d", cyc - done_cyc, GAP_CYCLES); end
    checks++; if (done_err != 0) begin failures++; $display("[TB] FAIL single_done_align: got %0d expected 0", done_err); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] m [3];
    bit r, ok;
    int n, d0, g0, i;
    m[0] = 64'h1;
    m[1] = 64'h8000_0000_0000_0000;
    m[2] = 64'hFFFF_FFFF_FFFF_FFFF;
    enable_i = 1'b0;
    rx_q.delete();
    start_q.delete();
    d0 = done_cnt;
    g0 = gap_data_err;
    for (int k = 0; k < 3; k++) applyStimulus(m[k], r, n);
    enable_i = 1'b1;
    i = 0;
    while (start_q.size() == 0 && i < 20) begin @(negedge clk_100MHz); i++; end
    spacing_q.delete();
    wait_rx(3, 1000, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL b2b_timeout: got %0d messages expected 3", rx_q.size()); end
    for (int k = 0; k < 3 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== m[k]) begin failures++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", k, rx_q[k], m[k]); end
    end
    checks++; if (spacing_q.size() != 2) begin failures++; $display("[TB] FAIL b2b_gaps: got %0d expected 2", spacing_q.size()); end
    for (int k = 0; k < spacing_q.size(); k++) begin
      checks++; if (spacing_q[k] != GAP_CYCLES + 2) begin failures++; $display("[TB] FAIL b2b_spacing%0d: got %0d expected %0d", k, spacing_q[k], GAP_CYCLES + 2); end
    end
    checks++; if (done_cnt - d0 != 3) begin failures++; $display("[TB] FAIL b2b_done: got %0d expected 3", done_cnt - d0); end
    checks++; if (gap_data_err != g0) begin failures++; $display("[TB] FAIL b2b_gap_data: got %0d expected %0d", gap_data_err, g0); end
    wait_idle(200, ok);
  endtask

  task automatic test_fifo_full();
    logic [63:0] w [5];
    bit r, ok;
    int n, i, s0;
    enable_i = 1'b0;
    rx_q.delete();
    for (int k = 0; k < 5; k++) begin
      w[k] = {$urandom, $urandom};
      applyStimulus(w[k], r, n);
      checks++; if (r !== (k < BUFFER_SIZE)) begin failures++; $display("[TB] FAIL full_ready_before%0d: got %b expected %b", k, r, k < BUFFER_SIZE); end
`ifdef SB_TX_LEVEL_EN
      if (k == 3) begin
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL full_overflow_early: got %b expected 0", overflow_o); end
      end
`endif
    end
    checks++; if (ready_o !== 1'b0) begin failures++; $display("[TB] FAIL full_ready: got %b expected 0", ready_o); end
`ifdef SB_TX_LEVEL_EN
    checks++; if (level_o !== 3'(BUFFER_SIZE)) begin failures++; $display("[TB] FAIL full_level: got %0d expected %0d", level_o, BUFFER_SIZE); end
    checks++; if (overflow_o !== 1'b1) begin failures++; $display("[TB] FAIL full_overflow: got %b expected 1", overflow_o); end
`endif
    s0 = start_q.size();
    enable_i = 1'b1;
    i = 0;
    while (!busy_o && i < 10) begin @(negedge clk_100MHz); i++; end
    checks++; if (!busy_o || ready_o !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_after_pop: got %b expected 1", ready_o); end
    wait_rx(4, 1200, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL full_timeout: got %0d messages expected 4", rx_q.size()); end
    for (int k = 0; k < 4 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== w[k]) begin failures++; $display("[TB] FAIL full_data%0d: got %h expected %h", k, rx_q[k], w[k]); end
    end
    wait_idle(200, ok);
    repeat (20) @(negedge clk_100MHz);
    checks++; if (start_q.size() - s0 != 4 || rx_q.size() != 4) begin failures++; $display("[TB] FAIL full_count: got %0d expected 4", start_q.size() - s0); end
`ifdef SB_TX_LEVEL_EN
    checks++; if (overflow_o !== 1'b1 || level_o !== '0) begin failures++; $display("[TB] FAIL full_sticky: got ovf=%b lvl=%0d expected ovf=1 lvl=0", overflow_o, level_o); end
`endif
  endtask

  task automatic test_enable_drop();
    logic [63:0] m [3];
    bit r, ok;
    int n, r0;
    enable_i = 1'b0;
    rx_q.delete();
    for (int k = 0; k < 3; k++) begin
      m[k] = {$urandom, $urandom};
      applyStimulus(m[k], r, n);
    end
    enable_i = 1'b1;
    wait_bits(10, 100, ok);
    enable_i = 1'b0;
    checks++; if (!ok) begin failures++; $display("[TB] FAIL drop_reach_bit10: got %0d expected 10", rx_bits); end
    wait_rx(1, 300, ok);
    checks++; if (!ok || rx_q[0] !== m[0]) begin failures++; $display("[TB] FAIL drop_msg1: got %0d messages expected 1", rx_q.size()); end
    wait_idle(200, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL drop_gap_end: got busy=%b expected 0", busy_o); end
    r0 = rise_cnt;
    repeat (150) @(negedge clk_100MHz);
    checks++; if (rise_cnt != r0 || rx_q.size() != 1) begin failures++; $display("[TB] FAIL drop_hold: got %0d edges expected 0", rise_cnt - r0); end
    enable_i = 1'b1;
    wait_rx(3, 600, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL drop_resume: got %0d messages expected 3", rx_q.size()); end
    for (int k = 1; k < 3 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== m[k]) begin failures++; $display("[TB] FAIL drop_data%0d: got %h expected %h", k, rx_q[k], m[k]); end
    end
    wait_idle(200, ok);
  endtask

  task automatic test_reset_mid();
    logic [63:0] m0, m1, m2;
    bit r, ok;
    int n, d0;
    m0 = {$urandom, $urandom};
    m1 = {$urandom, $urandom};
    m2 = {$urandom, $urandom};
    enable_i = 1'b1;
    rx_q.delete();
    d0 = done_cnt;
    applyStimulus(m0, r, n);
    applyStimulus(m1, r, n);
    wait_bits(20, 200, ok);
    @(negedge clk_100MHz);
    #2 reset = 1'b1;
    #1;
    checks++; if (clkPin_o !== 1'b0 || dataPin_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_pins: got clk=%b data=%b expected 0", clkPin_o, dataPin_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %b expected 0", busy_o); end
    checks++; if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready: got %b expected 1", ready_o); end
`ifdef SB_TX_LEVEL_EN
    checks++; if (level_o !== '0 || overflow_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_level: got %0d expected 0", level_o); end
`endif
    repeat (2) @(negedge clk_100MHz);
    reset = 1'b0;
    repeat (100) @(negedge clk_100MHz);
    checks++; if (rx_q.size() != 0 || busy_o !== 1'b0 || done_cnt != d0) begin failures++; $display("[TB] FAIL rst_abort: got %0d messages expected 0", rx_q.size()); end
    applyStimulus(m2, r, n);
    wait_rx(1, 400, ok);
    checks++; if (!ok || rx_q[0] !== m2) begin failures++; $display("[TB] FAIL rst_after: got %0d messages expected 1", rx_q.size()); end
    wait_idle(200, ok);
    repeat (20) @(negedge clk_100MHz);
    checks++; if (rx_q.size() != 1) begin failures++; $display("[TB] FAIL rst_flushed: got %0d messages expected 1", rx_q.size()); end
  endtask

  task automatic test_loopback();
    logic [63:0] exp_q [$];
    bit r, ok;
    int n, i, d0, g0;
    enable_i = 1'b1;
    rx_q.delete();
    d0 = done_cnt;
    g0 = gap_data_err;
    for (int k = 0; k < 6; k++) begin
      i = 0;
      while (!ready_o && i < 500) begin @(negedge clk_100MHz); i++; end
      exp_q.push_back({$urandom, $urandom});
      applyStimulus(exp_q[k], r, n);
      checks++; if (!r) begin failures++; $display("[TB] FAIL loop_accept%0d: got ready=0 expected 1", k); end
    end
    wait_rx(6, 2000, ok);
    checks++; if (!ok) begin failures++; $display("[TB] FAIL loop_timeout: got %0d messages expected 6", rx_q.size()); end
    for (int k = 0; k < 6 && k < rx_q.size(); k++) begin
      checks++; if (rx_q[k] !== exp_q[k]) begin failures++; $display("[TB] FAIL loop_data%0d: got %h expected %h", k, rx_q[k], exp_q[k]); end
    end
    checks++; if (done_cnt - d0 != 6) begin failures++; $display("[TB] FAIL loop_done: got %0d expected 6", done_cnt - d0); end
    checks++; if (done_err != 0 || gap_data_err != g0) begin failures++; $display("[TB] FAIL loop_align: got %0d/%0d expected 0/0", done_err, gap_data_err - g0); end
    wait_idle(200, ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fifo_full();
    test_enable_drop();
    test_reset_mid();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
